// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported Memory between the IFU (read-only) and the LSU.
// One transaction at a time: accept, hold strobes for LATENCY cycles, return the response.
module mem_arbiter #(
  parameter int         LATENCY  = 1,
  parameter logic [2:0] IFU_SIZE = 3'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_resp_data,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  input  logic [2:0]  lsu_req_size,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_resp_data,
  output logic [31:0] mem_waddr,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [2:0]  mem_rsize,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_lsu;
  logic          r_owner_lsu;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [7:0]    r_wmask;
  logic [2:0]    r_size;
  logic [CW-1:0] r_cnt;
  logic          r_mem_ren;
  logic          r_mem_wen;
  logic [31:0]   r_resp_data;

  logic w_grant_ifu;
  logic w_grant_lsu;
  logic w_accept;
  logic w_resp_fire;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant_ifu = ifu_req_valid & (~lsu_req_valid | r_last_lsu);
    w_grant_lsu = lsu_req_valid & (~ifu_req_valid | ~r_last_lsu);
    ifu_req_ready = (r_state == S_IDLE) & w_grant_ifu;
    lsu_req_ready = (r_state == S_IDLE) & w_grant_lsu;
    w_accept      = ifu_req_ready | lsu_req_ready;
    w_resp_fire   = (r_state == S_RESP) &
                    (r_owner_lsu ? lsu_resp_ready : ifu_resp_ready);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == '0) w_next = S_RESP;
      S_RESP:   if (w_resp_fire) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_lsu  <= 1'b1;
      r_owner_lsu <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_size      <= '0;
      r_cnt       <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_owner_lsu <= w_grant_lsu;
        r_last_lsu  <= w_grant_lsu;
        r_addr      <= w_grant_lsu ? lsu_req_addr : ifu_req_addr;
        r_wdata     <= w_grant_lsu ? lsu_req_wdata : 32'd0;
        r_wmask     <= w_grant_lsu ? lsu_req_wmask : 8'd0;
        r_size      <= w_grant_lsu ? lsu_req_size : IFU_SIZE;
        r_cnt       <= CW'(LATENCY - 1);
        r_mem_ren   <= ~(w_grant_lsu & lsu_req_wen);
        r_mem_wen   <= w_grant_lsu & lsu_req_wen;
      end
      // Last access cycle: capture read data while the strobe is still high.
      if (r_state == S_ACCESS) begin
        if (r_cnt == '0) begin
          r_resp_data <= r_mem_wen ? 32'd0 : mem_rdata;
          r_mem_ren   <= 1'b0;
          r_mem_wen   <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign mem_waddr      = r_addr;
  assign mem_raddr      = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;
  assign mem_rsize      = r_size;
  assign mem_ren        = r_mem_ren;
  assign mem_wen        = r_mem_wen;
  assign ifu_resp_valid = (r_state == S_RESP) & ~r_owner_lsu;
  assign lsu_resp_valid = (r_state == S_RESP) & r_owner_lsu;
  assign ifu_resp_data  = r_resp_data;
  assign lsu_resp_data  = r_resp_data;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported Memory block between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one request at a time through valid/ready handshakes and drives Memory's read/write strobes for a fixed access window.
- Captures the read data and returns a response to the owning requester through a valid/ready handshake.
- Sits between the IFU/LSU and Memory in the NPC core; round-robin arbitration on ties.

Parameters:
- LATENCY, 1, cycles the Memory strobes are held per access (must be >= 1); rdata is sampled on the last of these cycles.
- IFU_SIZE, 3'd4, fixed rsize driven for IFU reads (bytes).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ifu_req_valid  input  1  IFU fetch request
- ifu_req_ready  output  1  arbiter accepts the IFU request this cycle
- ifu_req_addr  input  32  fetch address
- ifu_resp_valid  output  1  fetch data available
- ifu_resp_ready  input  1  IFU consumes the response
- ifu_resp_data  output  32  fetched word
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  arbiter accepts the LSU request this cycle
- lsu_req_addr  input  32  load/store address
- lsu_req_wen  input  1  1 = store, 0 = load
- lsu_req_wdata  input  32  store data
- lsu_req_wmask  input  8  store byte mask
- lsu_req_size  input  3  load size in bytes
- lsu_resp_valid  output  1  load data / store acknowledge available
- lsu_resp_ready  input  1  LSU consumes the response
- lsu_resp_data  output  32  load data (0 for stores)
- mem_waddr  output  32  to Memory waddr
- mem_wmask  output  8  to Memory wmask
- mem_wdata  output  32  to Memory wdata
- mem_wen  output  1  to Memory wen
- mem_raddr  output  32  to Memory raddr
- mem_rsize  output  3  to Memory rsize
- mem_ren  output  1  to Memory ren
- mem_rdata  input  32  from Memory rdata

Behaviour:
- Clock and reset: single clock domain. reset is asynchronous, active-high, and clears all state immediately.
- Reset values: state=IDLE; all outputs 0; last_grant=LSU, so the IFU wins the first tie; all latched request and response registers 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, grant selection (combinational):
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - Only the granted requester sees req_ready=1; the other req_ready=0.
  - Handshake (valid & ready): latch owner, addr, wen, wdata, wmask, and size (IFU_SIZE for IFU); update last_grant=owner; load cnt=LATENCY-1; go to ACCESS.
  - No valid request: stay in IDLE.
- ACCESS:
  - Memory outputs are registered from the latched request.
  - Load: mem_ren=1, mem_raddr=addr, mem_rsize=size.
  - Store: mem_wen=1, mem_waddr=addr, mem_wdata=wdata, mem_wmask=wmask.
  - ren and wen are never high together. Strobes are 0 in every other state.
  - cnt decrements each cycle. On the cycle cnt==0: register mem_rdata into the response data (0 for stores) and go to RESP.
  - Duration is exactly LATENCY cycles.
- RESP:
  - The owner's resp_valid=1 and its resp_data holds the captured value, stable until resp_ready.
  - On resp_valid & resp_ready: drop resp_valid and go to IDLE.
  - The non-owner's resp_valid stays 0.
- Ready during busy: both req_ready=0 in ACCESS and RESP. Requests must hold valid and payload until accepted.
- Addresses and data outside ACCESS: mem address/data outputs keep their last latched values; only the strobes return to 0.
- Throughput: minimum LATENCY+2 cycles per transaction (accept, LATENCY access, 1 response with ready high).
- Width rules: pass-through only, no arithmetic on addresses. Counter width is clog2(LATENCY+1).
- Reset mid-operation: the in-flight transaction is dropped and no response is issued. Strobes fall immediately (asynchronously). After release the FSM is in IDLE with last_grant=LSU.
- Back-pressure: while resp_ready=0 the FSM stays in RESP indefinitely and no new request is accepted.

Test Plan:
- Reset, then ifu_req_valid=1, addr=0x80000000, mem_rdata=0x00000413, LATENCY=1 -> ready=1 at cycle 0; mem_ren=1, mem_raddr=0x80000000, mem_rsize=4 at cycle 1; ifu_resp_valid=1, data=0x00000413 at cycle 2.
- LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> one cycle with mem_wen=1 and matching waddr/wdata/wmask, mem_ren=0; lsu_resp_valid=1 with data=0.
- Both valid simultaneously after reset -> IFU granted first; on the next tie the LSU is granted; grants alternate over 4 back-to-back ties.
- LATENCY=3, LSU load of 1 byte, mem_rdata changes each cycle -> mem_ren high for exactly 3 cycles; resp data equals mem_rdata on the 3rd cycle.
- Hold ifu_resp_ready=0 for 5 cycles -> resp_valid and data stay stable; lsu_req_ready=0 throughout; LSU is accepted the cycle after resp_ready=1.
- Assert reset during ACCESS -> mem_ren falls without a clock edge; no resp_valid after release; a new request is accepted from IDLE.
